// File: rtl/rfft_pkg.sv
// Shared constants and FSM encoding for the RFFT input loader.
package rfft_pkg;
  localparam int WIDTH = 16;
  localparam int NPTS  = 256;
  localparam int LANES = 4;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD, RUN, HOLD} state_t;
endpackage

// File: rtl/rfft_loader_buf.sv
// Staging banks for lanes 0..2: one write port (bank + address), and a
// registered read that fetches the same address from every bank at once.
module rfft_loader_buf #(
  parameter int WIDTH = rfft_pkg::WIDTH
) (
  input  logic                                     Clk,
  input  logic                                     Reset,
  input  logic                                     Wr_en,
  input  logic [1:0]                               Wr_bank,
  input  logic [rfft_pkg::AW-1:0]                  Wr_addr,
  input  logic [WIDTH-1:0]                         Wr_data,
  input  logic                                     Rd_en,
  input  logic [rfft_pkg::AW-1:0]                  Rd_addr,
  output logic [rfft_pkg::LANES-2:0][WIDTH-1:0]    Rd_data
);
  import rfft_pkg::*;

  for (genvar b = 0; b < LANES-1; b++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Bank write; storage is never cleared, only the read register is.
    always_ff @(posedge Clk)
      if (Wr_en && Wr_bank == 2'(b)) mem[Wr_addr] <= Wr_data;

    // Common-address read, one cycle latency.
    always_ff @(posedge Clk or posedge Reset)
      if (Reset)      rd_q <= '0;
      else if (Rd_en) rd_q <= mem[Rd_addr];

    assign Rd_data[b] = rd_q;
  end
endmodule

// File: rtl/rfft_loader.sv
// Streams a 256-sample frame into a 4-lane FFT core. Samples 0..191 are
// parked in three banks; each of samples 192..255 triggers one RAM write
// carrying the three parked lanes plus the live sample as lane 3.
// Optional: define RFFT_LOADER_SCALE_EN to pre-shift every sample right by 2.
module rfft_loader #(
  parameter int WIDTH = rfft_pkg::WIDTH,
  parameter int NPTS  = rfft_pkg::NPTS
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         S_data,
  input  logic                     S_valid,
  output logic                     S_ready,
  output logic [WIDTH-1:0]         Din0,
  output logic [WIDTH-1:0]         Din1,
  output logic [WIDTH-1:0]         Din2,
  output logic [WIDTH-1:0]         Din3,
  output logic [rfft_pkg::AW-1:0]  Addr,
  output logic                     Write,
  output logic                     Input,
  input  logic                     Fft_done,
  input  logic [rfft_pkg::AW-1:0]  Rd_addr,
  output logic                     Res_valid,
  input  logic                     Rd_release
);
  import rfft_pkg::*;

  localparam int NW = $clog2(NPTS);

  state_t                      state, next_state;
  logic [NW-1:0]               n;
  logic [1:0]                  lane;
  logic [AW-1:0]               slot;
  logic [WIDTH-1:0]            sample;
  logic                        accept;
  logic                        live;
  logic                        s_ready_d, write_d, input_d, res_valid_d;
  logic [AW-1:0]               addr_q;
  logic [WIDTH-1:0]            din3_q;
  logic [LANES-2:0][WIDTH-1:0] bank_q;

  assign lane   = n[NW-1 -: 2];
  assign slot   = n[AW-1:0];
  assign accept = S_valid && S_ready && (state == LOAD);
  assign live   = (lane == 2'd3);

`ifdef RFFT_LOADER_SCALE_EN
  assign sample = WIDTH'($signed(S_data) >>> 2);
`else
  assign sample = S_data;
`endif

  rfft_loader_buf #(.WIDTH(WIDTH)) u_buf (
    .Clk     (Clk),
    .Reset   (Reset),
    .Wr_en   (accept && !live),
    .Wr_bank (lane),
    .Wr_addr (slot),
    .Wr_data (sample),
    .Rd_en   (accept && live),
    .Rd_addr (slot),
    .Rd_data (bank_q)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= LOAD;
    else       state <= next_state;

  // Next state: the write of the last slot closes the frame.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (Write && addr_q == AW'(DEPTH-1)) next_state = RUN;
      RUN:     if (Fft_done)                        next_state = HOLD;
      HOLD:    if (Rd_release)                      next_state = LOAD;
      default:                                      next_state = LOAD;
    endcase
  end

  // Next values of the registered control outputs.
  always_comb begin
    input_d     = (next_state != RUN);
    res_valid_d = (next_state == HOLD);
    write_d     = accept && live;
    s_ready_d   = (next_state == LOAD) && !(accept && n == NW'(NPTS-1));
  end

  // Output registers and sample counter; counter restarts whenever not loading.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      S_ready   <= 1'b0;
      Input     <= 1'b1;
      Write     <= 1'b0;
      Res_valid <= 1'b0;
      addr_q    <= '0;
      din3_q    <= '0;
      n         <= '0;
    end else begin
      S_ready   <= s_ready_d;
      Input     <= input_d;
      Write     <= write_d;
      Res_valid <= res_valid_d;
      if (write_d) begin
        addr_q <= slot;
        din3_q <= sample;
      end
      if (state != LOAD) n <= '0;
      else if (accept)   n <= n + 1'b1;
    end

  assign Addr = (state == HOLD) ? Rd_addr : addr_q;
  assign Din0 = bank_q[0];
  assign Din1 = bank_q[1];
  assign Din2 = bank_q[2];
  assign Din3 = din3_q;
endmodule

// File: doc/rfft_loader.md
RFFT_LOADER -- requirements
Module: rfft_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter NPTS, default 256, frame length in samples (fixed at 4 lanes x 64 addresses).
REQ-003 SHALL have port Clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port S_data  input  WIDTH  signed sample stream, in natural order n=0..255.
REQ-006 SHALL have ports S_valid input 1 and S_ready output 1: a sample is accepted in any cycle where both are high.
REQ-007 SHALL have ports Din0..Din3  output  WIDTH each  lane data to the FFT core.
REQ-008 SHALL have ports Addr output 6 (FFT RAM address), Write output 1 (RAM write strobe), Input output 1 (core load/hold mode).
REQ-009 SHALL have port Fft_done  input  1  completion flag from the FFT core.
REQ-010 SHALL have ports Rd_addr input 6, Res_valid output 1, Rd_release input 1 for the downstream result reader.

Function
REQ-011 SHALL implement a three-state FSM: LOAD, RUN, HOLD.
REQ-012 In LOAD, SHALL drive S_ready=1, Input=1, and SHALL count accepted samples with an 8-bit counter n.
REQ-013 Sample n SHALL map to lane n[7:6] and address n[5:0].
REQ-014 For n<192, SHALL store the sample in internal bank n[7:6] at address n[5:0], with Write=0.
REQ-015 For n>=192, SHALL pulse Write=1 exactly one cycle after acceptance, with Addr=n[5:0], Din0..2 taken from banks 0..2 at that address, and Din3 taken from the registered live sample.
REQ-016 S_valid gaps SHALL stall the counter; Write SHALL only follow an accepted sample.
REQ-017 After the Write for n=255, SHALL move to RUN on the next edge; S_ready SHALL be 0 from the cycle in which sample 255 is accepted.
REQ-018 In RUN, SHALL drive Input=0, Write=0, S_ready=0, and SHALL stay in RUN until Fft_done=1.
REQ-019 On Fft_done=1 in RUN, SHALL move to HOLD.
REQ-020 In HOLD, SHALL drive Input=1, Write=0, Res_valid=1, and Addr=Rd_addr combinationally.
REQ-021 Rd_release=1 in HOLD SHALL return the FSM to LOAD with n=0. Rd_release SHALL be ignored in other states.
REQ-022 Input, Write, S_ready, and Res_valid SHALL be registered, except that Addr in HOLD is a mux of Rd_addr.

Reset
REQ-023 On Reset, SHALL enter LOAD with n=0, Input=1, Write=0, Res_valid=0, Addr=0, Din0..3=0. S_ready SHALL be 0 while Reset is high and 1 from the first edge after release.
REQ-024 Reset mid-frame or mid-RUN SHALL discard the partial frame; bank contents need not be cleared.

Configuration
REQ-025 With RFFT_LOADER_SCALE_EN defined, each accepted sample SHALL be arithmetic-shifted right by 2 (sign-preserving) before storage or use as Din3. Without it, samples SHALL pass unmodified.

Structure
REQ-026 Package rfft_pkg SHALL hold WIDTH, NPTS, LANES=4, DEPTH=64, and the FSM state enum.
REQ-027 SHALL instantiate one sub-module, rfft_loader_buf: three 64xWIDTH banks with a single write port (bank select plus address) and a synchronous 1-cycle read that reads all three banks at a common address.

Verification
REQ-028 Ramp S_data=n with S_valid held 1 -> 64 Write pulses on cycles 193..256; the Write at Addr=5 carries Din0=5, Din1=69, Din2=133, Din3=197.
REQ-029 S_valid toggling 1/0 during the ramp -> identical Write data, exactly 64 pulses, and no Write without a preceding acceptance.
REQ-030 After the last Write -> Input=0 next cycle. Fft_done pulsed 500 cycles later -> Input=1 and Res_valid=1 next cycle, and Addr tracks Rd_addr=0x2A.
REQ-031 Reset asserted at n=150 then released, followed by a full ramp of 0..255 -> output identical to REQ-028.
REQ-032 With RFFT_LOADER_SCALE_EN, S_data=-8 at n=192 -> Din3=-2 at Addr=0.
REQ-033 Rd_release asserted in RUN -> no effect. Rd_release asserted in HOLD -> LOAD, S_ready=1, and the next frame is accepted starting at n=0.
